key_input_pio: RTL and testbench
================================

# key_input_pio

Avalon-MM slave input PIO for the ECE178 Nios II system, the input-side counterpart of the HEX/LED output PIOs. It synchronizes and debounces `WIDTH` asynchronous board inputs (KEY buttons or switches), exposes the debounced level to software, and latches selected edges into an edge-capture register. A maskable level interrupt goes to the Nios II IRQ controller.

## Interface
- `WIDTH`, 4: number of input bits, 1..32.
- `DEBOUNCE_CYCLES`, 50000: consecutive stable `clk` cycles required to accept a new level (1 ms at 50 MHz); minimum 1.
- `EDGE_TYPE`, 1: edge that sets edge-capture bits; 0 = rising, 1 = falling, 2 = any.

- `clk`  in  1  system clock
- `reset_n`  in  1  reset; asynchronous, active-low. Clock is `clk`.
- `address`  in  2  word address
- `chipselect`  in  1  slave select
- `write_n`  in  1  active-low write strobe
- `writedata`  in  32  write data
- `readdata`  out  32  read data, zero-wait-state (readLatency 0)
- `in_port`  in  WIDTH  raw asynchronous inputs
- `irq`  out  1  level interrupt, active-high

## Operation
- Register map (word addresses):
  - 0 DATA, RO: debounced level, zero-extended.
  - 1 DIRECTION, RO: reads 0 (input-only).
  - 2 IRQMASK, RW: bits [WIDTH-1:0]; upper bits read 0.
  - 3 EDGECAP, R/W1C: each bit is set by the selected edge on the debounced level and cleared by writing 1 to it.
- Writes take effect when `chipselect && !write_n`; writes to addresses 0 and 1 are ignored.
- `readdata` is a combinational mux on `address` alone, independent of `chipselect`.
- Per bit:
  - A 2-flop synchronizer feeds `sync`.
  - A counter increments while `sync != stable` and clears when `sync == stable`.
  - When the counter reaches `DEBOUNCE_CYCLES-1` and `sync` still differs, `stable <= sync` and the counter clears.
  - Counter width is `$clog2(DEBOUNCE_CYCLES)`, minimum 1.
- Edge event: the cycle `stable` updates and the direction matches `EDGE_TYPE`.
- `irq = |(EDGECAP & IRQMASK)`, combinational from registers.
- Boundary rules:
  - Edge event and W1C on the same bit in the same cycle: set wins, bit stays 1.
  - Glitch shorter than `DEBOUNCE_CYCLES`: counter clears and no DATA or EDGECAP change.
  - Writing 0 bits to EDGECAP leaves them unchanged.
  - Masking a set EDGECAP bit drops `irq` but does not clear the bit.
  - `reset_n` low mid-count: asynchronously clears sync flops, counters, `stable`, IRQMASK and EDGECAP.

## Timing
- Reset values:
  - `readdata` is 0 for every address.
  - `irq` is 0.
  - `stable`, sync flops, counters, IRQMASK and EDGECAP are all 0.
- Input latency with N = `DEBOUNCE_CYCLES`: a level first sampled at edge k appears in DATA after edge k+1+N. Two edges go to synchronization, then N to the counter, with one shared.
- EDGECAP sets on that same edge, and `irq` is high immediately after it if the bit is masked in.
- Register writes land on the `clk` edge of the write cycle and are visible on `readdata` in the next cycle.
- Startup with active-low KEY idle high: DATA rises to 1 about N+2 cycles after reset. With default `EDGE_TYPE=1` this is not captured; with 0 or 2 it is, and software must clear EDGECAP before enabling IRQMASK.

## Structure
- Package `ece178_pio_pkg`:
  - address constants `PIO_ADDR_DATA/DIR/IRQMASK/EDGECAP`
  - edge encodings `EDGE_RISE/FALL/ANY`
- Sub-module `input_debouncer` (synchronizer, counter, `stable`, one-cycle `rise`/`fall` pulses), instantiated `WIDTH` times via generate.
- The top level holds the register file, edge-capture logic, read mux and `irq`.

## Test plan
- Reset check: after reset, read all four addresses -> 0 each; `irq`=0.
- Debounce, N=4, WIDTH=4: hold `in_port`=4'hF, then `in_port[0]` 1->0 for 3 cycles and back -> DATA stays 4'hF, EDGECAP stays 0. Hold 0 for 10 cycles -> DATA=4'hE, reached exactly N+2 edges after the change.
- Interrupt path: IRQMASK=4'h1, then press bit 0 (falling) -> EDGECAP=4'h1 and `irq`=1. Write EDGECAP=4'h1 -> EDGECAP=0, `irq`=0 next cycle.
- Mask and W1C: press bit 2 with IRQMASK=4'h1 -> EDGECAP=4'h4, `irq`=0. Write EDGECAP=4'h2 -> EDGECAP still 4'h4.
- Simultaneous set and clear: time a W1C of bit 1 to the cycle its debounced edge lands -> EDGECAP[1]=1.
- Reset mid-count: assert `reset_n` mid-debounce, then release with input held -> full N+2 latency restarts and DATA starts at 0.

Source files
------------

// File: rtl/ece178_pio_pkg.sv
// Shared constants for the ECE178 Avalon-MM PIO blocks: register map and edge encodings.
package ece178_pio_pkg;

  localparam int unsigned PIO_DATA_W = 32;
  localparam int unsigned PIO_ADDR_W = 2;

  localparam logic [PIO_ADDR_W-1:0] PIO_ADDR_DATA    = 2'd0;
  localparam logic [PIO_ADDR_W-1:0] PIO_ADDR_DIR     = 2'd1;
  localparam logic [PIO_ADDR_W-1:0] PIO_ADDR_IRQMASK = 2'd2;
  localparam logic [PIO_ADDR_W-1:0] PIO_ADDR_EDGECAP = 2'd3;

  localparam int unsigned EDGE_RISE = 0;
  localparam int unsigned EDGE_FALL = 1;
  localparam int unsigned EDGE_ANY  = 2;

  // Debounce counter width; a single-cycle debounce still needs one bit.
  function automatic int unsigned cnt_width(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/key_input_pio_if.sv
// Avalon-MM slave bus bundle for the input PIO (zero-wait-state reads).
interface key_input_pio_if;
  import ece178_pio_pkg::*;

  logic [PIO_ADDR_W-1:0] address;
  logic                  chipselect;
  logic                  write_n;
  logic [PIO_DATA_W-1:0] writedata;
  logic [PIO_DATA_W-1:0] readdata;

  modport master (output address, chipselect, write_n, writedata, input readdata);
  modport slave  (input address, chipselect, write_n, writedata, output readdata);
endinterface

// File: rtl/input_debouncer.sv
// One-bit synchronizer and debouncer; rise/fall pulse in the cycle stable is about to change.
module input_debouncer
  import ece178_pio_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = 50000
) (
  input  logic clk,
  input  logic reset_n,
  input  logic din,
  output logic stable,
  output logic rise,
  output logic fall
);

  localparam int unsigned       CNT_W    = cnt_width(DEBOUNCE_CYCLES);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic             sync_meta;
  logic             sync;
  logic [CNT_W-1:0] cnt;
  logic             accept_c;

  assign accept_c = (sync != stable) && (cnt == CNT_LAST);
  assign rise     = accept_c &  sync;
  assign fall     = accept_c & ~sync;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sync_meta <= 1'b0;
      sync      <= 1'b0;
      stable    <= 1'b0;
      cnt       <= '0;
    end else begin
      sync_meta <= din;
      sync      <= sync_meta;
      if (sync == stable) begin
        cnt <= '0;
      end else if (accept_c) begin
        stable <= sync;
        cnt    <= '0;
      end else begin
        cnt <= cnt + CNT_W'(1);
      end
    end
  end

endmodule

// File: rtl/key_input_pio.sv
// Avalon-MM input PIO: debounced DATA, read-only DIRECTION, IRQMASK and W1C EDGECAP with level irq.
module key_input_pio
  import ece178_pio_pkg::*;
#(
  parameter int unsigned WIDTH           = 4,
  parameter int unsigned DEBOUNCE_CYCLES = 50000,
  parameter int unsigned EDGE_TYPE       = 1
) (
  input  logic               clk,
  input  logic               reset_n,
  key_input_pio_if.slave     bus,
  input  logic [WIDTH-1:0]   in_port,
  output logic               irq
);

  logic [WIDTH-1:0] stable;
  logic [WIDTH-1:0] rise;
  logic [WIDTH-1:0] fall;
  logic [WIDTH-1:0] edge_set_c;
  logic [WIDTH-1:0] cap_clr_c;
  logic [WIDTH-1:0] irqmask;
  logic [WIDTH-1:0] edgecap;
  logic             wr_c;
  logic             unused_wdata;

  for (genvar i = 0; i < int'(WIDTH); i++) begin : g_deb
    input_debouncer #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_deb (
      .clk    (clk),
      .reset_n(reset_n),
      .din    (in_port[i]),
      .stable (stable[i]),
      .rise   (rise[i]),
      .fall   (fall[i])
    );
  end

  // Upper write-data bits have no storage behind them.
  assign unused_wdata = ^bus.writedata;

  assign wr_c      = bus.chipselect && !bus.write_n;
  assign cap_clr_c = (wr_c && (bus.address == PIO_ADDR_EDGECAP)) ? bus.writedata[WIDTH-1:0] : '0;

  always_comb begin
    edge_set_c = rise | fall;
    case (EDGE_TYPE)
      EDGE_RISE: edge_set_c = rise;
      EDGE_FALL: edge_set_c = fall;
      default:   edge_set_c = rise | fall;
    endcase
  end

  // Set beats clear when an edge and a W1C hit the same bit together.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      irqmask <= '0;
      edgecap <= '0;
    end else begin
      if (wr_c && (bus.address == PIO_ADDR_IRQMASK)) begin
        irqmask <= bus.writedata[WIDTH-1:0];
      end
      edgecap <= (edgecap & ~cap_clr_c) | edge_set_c;
    end
  end

  always_comb begin
    bus.readdata = '0;
    case (bus.address)
      PIO_ADDR_DATA:    bus.readdata = PIO_DATA_W'(stable);
      PIO_ADDR_IRQMASK: bus.readdata = PIO_DATA_W'(irqmask);
      PIO_ADDR_EDGECAP: bus.readdata = PIO_DATA_W'(edgecap);
      default:          bus.readdata = '0;
    endcase
  end

  assign irq = |(edgecap & irqmask);

endmodule

// File: tb/tb_key_input_pio.sv
// Self-checking bench for key_input_pio: directed boundary cases plus randomized traffic vs. a window model.
module tb_key_input_pio;
  import ece178_pio_pkg::*;

  localparam int unsigned W  = 4;
  localparam int unsigned N  = 4;
  localparam int unsigned ET = 1;

  logic         clk;
  logic         reset_n;
  logic [W-1:0] in_port;
  logic         irq;

  key_input_pio_if bus_if ();

  key_input_pio #(
    .WIDTH          (W),
    .DEBOUNCE_CYCLES(N),
    .EDGE_TYPE      (ET)
  ) dut (
    .clk    (clk),
    .reset_n(reset_n),
    .bus    (bus_if.slave),
    .in_port(in_port),
    .irq    (irq)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", tag, obs, exp, $time);
    end
  endtask

  // Reference model: a level is accepted once N consecutive synchronized samples agree
  // and differ from the current level; samples reach the sync stage two edges late.
  logic [W-1:0] hist[$];
  logic [W-1:0] m_stable, m_mask, m_cap, m_evt, m_clr;
  logic         m_same, m_wr;

  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      hist.delete();
      for (int i = 0; i < int'(N) + 2; i++) hist.push_back('0);
      m_stable = '0;
      m_mask   = '0;
      m_cap    = '0;
    end else begin
      hist.push_back(in_port);
      void'(hist.pop_front());
      m_evt = '0;
      for (int b = 0; b < int'(W); b++) begin
        m_same = 1'b1;
        for (int j = 1; j < int'(N); j++)
          if (hist[j][b] !== hist[0][b]) m_same = 1'b0;
        if (m_same && (hist[0][b] !== m_stable[b])) begin
          m_stable[b] = hist[0][b];
          m_evt[b]    = (ET == 2) ? 1'b1 : ((ET == 1) ? !hist[0][b] : hist[0][b]);
        end
      end
      m_wr  = bus_if.chipselect && !bus_if.write_n;
      m_clr = (m_wr && bus_if.address == 2'd3) ? bus_if.writedata[W-1:0] : '0;
      if (m_wr && bus_if.address == 2'd2) m_mask = bus_if.writedata[W-1:0];
      m_cap = (m_cap & ~m_clr) | m_evt;
    end
  end

  function automatic logic [31:0] model_rd(input logic [1:0] a);
    case (a)
      2'd0:    return 32'(m_stable);
      2'd2:    return 32'(m_mask);
      2'd3:    return 32'(m_cap);
      default: return 32'h0;
    endcase
  endfunction

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic set_in(input logic [W-1:0] v);
    @(negedge clk);
    in_port = v;
  endtask

  task automatic wr(input logic [1:0] a, input logic [31:0] d);
    @(negedge clk);
    bus_if.address    = a;
    bus_if.writedata  = d;
    bus_if.chipselect = 1'b1;
    bus_if.write_n    = 1'b0;
    @(negedge clk);
    bus_if.chipselect = 1'b0;
    bus_if.write_n    = 1'b1;
  endtask

  task automatic rd_check(input string tag, input logic [1:0] a, input logic [31:0] exp);
    @(negedge clk);
    bus_if.address    = a;
    bus_if.chipselect = 1'b1;
    bus_if.write_n    = 1'b1;
    #1;
    check_val(tag, bus_if.readdata, exp);
  endtask

  logic [1:0] ra;

  initial begin
    reset_n           = 1'b0;
    in_port           = '0;
    bus_if.address    = '0;
    bus_if.chipselect = 1'b0;
    bus_if.write_n    = 1'b1;
    bus_if.writedata  = '0;
    idle(3);
    reset_n = 1'b1;

    rd_check("rst_data", 2'd0, 32'h0);
    rd_check("rst_dir",  2'd1, 32'h0);
    rd_check("rst_mask", 2'd2, 32'h0);
    rd_check("rst_cap",  2'd3, 32'h0);
    check_val("rst_irq", 32'(irq), 32'h0);

    // Idle-high keys: rising startup level, not captured with falling-edge capture.
    set_in(4'hF);
    idle(10);
    rd_check("start_data", 2'd0, 32'hF);
    rd_check("start_cap",  2'd3, 32'h0);

    // 3-cycle glitch on bit 0 is rejected.
    set_in(4'hE);
    idle(2);
    set_in(4'hF);
    idle(10);
    rd_check("glitch_data", 2'd0, 32'hF);
    rd_check("glitch_cap",  2'd3, 32'h0);

    // Exact latency: N+2 edges from the first sampling edge.
    @(negedge clk);
    bus_if.address = 2'd0;
    in_port        = 4'hE;
    repeat (N + 1) @(posedge clk);
    #1 check_val("lat_early", bus_if.readdata, 32'hF);
    @(posedge clk);
    #1 check_val("lat_exact", bus_if.readdata, 32'hE);
    rd_check("lat_cap", 2'd3, 32'h1);
    wr(2'd3, 32'hF);
    rd_check("lat_cap_clr", 2'd3, 32'h0);

    // Interrupt path.
    set_in(4'hF);
    idle(10);
    wr(2'd2, 32'h1);
    set_in(4'hE);
    idle(10);
    rd_check("irq_cap", 2'd3, 32'h1);
    check_val("irq_hi", 32'(irq), 32'h1);
    wr(2'd3, 32'h1);
    #1 check_val("irq_lo", 32'(irq), 32'h0);
    rd_check("irq_cap_clr", 2'd3, 32'h0);

    // Masked-out capture and writing zeros to EDGECAP.
    set_in(4'hF);
    idle(10);
    set_in(4'hB);
    idle(10);
    rd_check("mask_cap", 2'd3, 32'h4);
    check_val("mask_irq", 32'(irq), 32'h0);
    wr(2'd3, 32'h2);
    rd_check("w1c_other", 2'd3, 32'h4);
    wr(2'd2, 32'h0);
    rd_check("mask_clr_keep", 2'd3, 32'h4);
    wr(2'd3, 32'h4);
    rd_check("w1c_bit2", 2'd3, 32'h0);

    // W1C of bit 1 on the very edge its debounced fall lands.
    set_in(4'hF);
    idle(10);
    @(negedge clk);
    in_port = 4'hD;
    repeat (N + 1) @(negedge clk);
    bus_if.address    = 2'd3;
    bus_if.writedata  = 32'h2;
    bus_if.chipselect = 1'b1;
    bus_if.write_n    = 1'b0;
    @(negedge clk);
    bus_if.chipselect = 1'b0;
    bus_if.write_n    = 1'b1;
    rd_check("setwin_cap",  2'd3, 32'h2);
    rd_check("setwin_data", 2'd0, 32'hD);
    wr(2'd3, 32'h2);

    // Reset in the middle of a debounce count restarts the full latency.
    set_in(4'hF);
    idle(10);
    set_in(4'hE);
    idle(2);
    @(negedge clk);
    bus_if.address = 2'd0;
    reset_n        = 1'b0;
    #1 check_val("midrst_data", bus_if.readdata, 32'h0);
    @(negedge clk);
    reset_n = 1'b1;
    repeat (N + 1) @(posedge clk);
    #1 check_val("midrst_early", bus_if.readdata, 32'h0);
    @(posedge clk);
    #1 check_val("midrst_exact", bus_if.readdata, 32'hE);
    rd_check("midrst_cap", 2'd3, 32'h0);

    // Randomized traffic against the model.
    for (int it = 0; it < 400; it++) begin
      case ($urandom_range(0, 9))
        0, 1, 2, 3: set_in(W'($urandom));
        4, 5:       wr(2'($urandom_range(0, 3)), $urandom);
        default:    idle(int'($urandom_range(1, 6)));
      endcase
      ra = 2'($urandom_range(0, 3));
      @(negedge clk);
      bus_if.address    = ra;
      bus_if.chipselect = 1'($urandom_range(0, 1));
      bus_if.write_n    = 1'b1;
      #1;
      check_val("rnd_rd",  bus_if.readdata, model_rd(ra));
      check_val("rnd_irq", 32'(irq), 32'(|(m_cap & m_mask)));
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
